// File: rtl/div_fifo_reader.sv
// Pops division requests from a FIFO, runs a 32-cycle radix-2 restoring divider and holds the result until acked.
// Optional macro DIV_FIFO_DIVZERO_BYPASS_EN: divide-by-zero requests skip the divider and complete one cycle after the pop.
module div_fifo_reader #(
  parameter int ID_WIDTH = 3,
  parameter int XLEN     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fifo_valid,
  input  logic [2*XLEN+2+ID_WIDTH-1:0]  fifo_data_out,
  output logic                          fifo_pop,
  output logic                          wb_valid,
  input  logic                          wb_ack,
  output logic [XLEN-1:0]               wb_rd,
  output logic [ID_WIDTH-1:0]           wb_id
);

  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]     rs1_in, rs2_in;
  logic [1:0]          op_in;
  logic [ID_WIDTH-1:0] id_in;

  assign rs1_in = fifo_data_out[XLEN-1:0];
  assign rs2_in = fifo_data_out[2*XLEN-1:XLEN];
  assign op_in  = fifo_data_out[2*XLEN+1:2*XLEN];
  assign id_in  = fifo_data_out[2*XLEN+2+ID_WIDTH-1:2*XLEN+2];

  logic [4:0]          cnt_q, cnt_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic [XLEN-1:0]     quo_q, quo_d;
  logic [XLEN-1:0]     divisor_q, divisor_d;
  logic                is_rem_q, is_rem_d;
  logic                neg_q_q, neg_q_d;
  logic                neg_r_q, neg_r_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [XLEN-1:0]     wb_rd_q, wb_rd_d;
  logic [ID_WIDTH-1:0] wb_id_q, wb_id_d;

  // NOTE: state registers take non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaulting every combinational output first keeps the case from inferring latches.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          state_d = DIVIDE;
`ifdef DIV_FIFO_DIVZERO_BYPASS_EN
          if (rs2_in == '0) state_d = DONE;
`endif
        end
      end
      DIVIDE:  if (cnt_q == 5'd0) state_d = FIXUP;
      FIXUP:   state_d = DONE;
      DONE:    if (wb_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the pop so a request is never dequeued while it would be discarded.
  always_comb begin
    fifo_pop = (state_q == IDLE) && fifo_valid && !rst;
    wb_valid = (state_q == DONE);
  end

  logic            signed_op;
  logic [XLEN:0]   rem_shift, trial;
  logic [XLEN-1:0] q_res, r_res;

  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    is_rem_d  = is_rem_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    id_d      = id_q;
    wb_rd_d   = wb_rd_q;
    wb_id_d   = wb_id_q;
    signed_op = ~op_in[0];
    rem_shift = (rem_q << 1) | {{XLEN{1'b0}}, quo_q[XLEN-1]};
    trial     = rem_shift - {1'b0, divisor_q};
    q_res     = neg_q_q ? -quo_q : quo_q;
    r_res     = neg_r_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    if (divisor_q == '0) q_res = '1;

    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          quo_d     = (signed_op && rs1_in[XLEN-1]) ? -rs1_in : rs1_in;
          divisor_d = (signed_op && rs2_in[XLEN-1]) ? -rs2_in : rs2_in;
          rem_d     = '0;
          cnt_d     = 5'd31;
          neg_q_d   = signed_op & (rs1_in[XLEN-1] ^ rs2_in[XLEN-1]);
          neg_r_d   = signed_op & rs1_in[XLEN-1];
          is_rem_d  = op_in[1];
          id_d      = id_in;
`ifdef DIV_FIFO_DIVZERO_BYPASS_EN
          if (rs2_in == '0) begin
            wb_rd_d = op_in[1] ? rs1_in : '1;
            wb_id_d = id_in;
          end
`endif
        end
      end
      DIVIDE: begin
        // Restoring step: keep the trial difference only when it did not go negative.
        if (!trial[XLEN]) begin
          rem_d = trial;
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_shift;
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
      end
      FIXUP: begin
        wb_rd_d = is_rem_q ? r_res : q_res;
        wb_id_d = id_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      is_rem_q  <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      id_q      <= '0;
      wb_rd_q   <= '0;
      wb_id_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      is_rem_q  <= is_rem_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      id_q      <= id_d;
      wb_rd_q   <= wb_rd_d;
      wb_id_q   <= wb_id_d;
    end
  end

  assign wb_rd = wb_rd_q;
  assign wb_id = wb_id_q;

endmodule

// File: tb/tb_div_fifo_reader.sv
// Directed bench for div_fifo_reader: vector table plus hand-written stall and reset sequences.
// Build with DIV_FIFO_DIVZERO_BYPASS_EN defined to expect the one-cycle divide-by-zero path.
module tb_div_fifo_reader;
  localparam int ID_WIDTH = 3;
  localparam int XLEN     = 32;
`ifdef DIV_FIFO_DIVZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         fifo_valid;
  logic [2*XLEN+2+ID_WIDTH-1:0] fifo_data_out;
  logic                         fifo_pop;
  logic                         wb_valid;
  logic                         wb_ack;
  logic [XLEN-1:0]              wb_rd;
  logic [ID_WIDTH-1:0]          wb_id;

  always #5 clk = ~clk;

  div_fifo_reader #(.ID_WIDTH(ID_WIDTH), .XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_valid    (fifo_valid),
    .fifo_data_out (fifo_data_out),
    .fifo_pop      (fifo_pop),
    .wb_valid      (wb_valid),
    .wb_ack        (wb_ack),
    .wb_rd         (wb_rd),
    .wb_id         (wb_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [1:0]  op;
    logic [2:0]  id;
    logic [31:0] exp_rd;
  } vec_t;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  function automatic logic [2*XLEN+2+ID_WIDTH-1:0] pack(input logic [31:0] rs1, input logic [31:0] rs2,
                                                        input logic [1:0] op, input logic [2:0] id);
    return {id, op, rs2, rs1};
  endfunction

  function automatic int exp_lat(input logic [31:0] rs2);
    return (BYPASS && rs2 == 32'd0) ? 1 : 34;
  endfunction

  // Present a request at a negedge (cycle 0) and confirm it is popped immediately.
  task automatic issue(input string name, input logic [2*XLEN+2+ID_WIDTH-1:0] data);
    @(negedge clk);
    fifo_valid    = 1'b1;
    fifo_data_out = data;
    #1 check({name, "_pop"}, fifo_pop, 1);
  endtask

  // From cycle 0, drive the FIFO for cycle 1 onward and wait for wb_valid; a stray ack is pulsed mid-divide.
  task automatic wait_result(input string name, input logic [31:0] exp_rd, input logic [2:0] exp_id,
                             input int lat_exp, input logic nxt_valid,
                             input logic [2*XLEN+2+ID_WIDTH-1:0] nxt_data);
    int lat;
    @(negedge clk);
    fifo_valid    = nxt_valid;
    fifo_data_out = nxt_data;
    lat = 1;
    forever begin
      #1 check({name, "_nopop"}, fifo_pop, 0);
      if (wb_valid || lat >= 100) break;
      @(negedge clk);
      lat++;
      if (lat == 5) wb_ack = 1'b1;
      if (lat == 6) wb_ack = 1'b0;
    end
    check({name, "_latency"}, lat, lat_exp);
    check({name, "_rd"}, wb_rd, exp_rd);
    check({name, "_id"}, wb_id, {29'd0, exp_id});
  endtask

  task automatic ack(input string name);
    wb_ack = 1'b1;
    #1 check({name, "_ackpop"}, fifo_pop, 0);
    @(negedge clk);
    wb_ack = 1'b0;
    #1 check({name, "_idle"}, wb_valid, 0);
  endtask

  vec_t vecs[16];

  initial begin
    int seen;
    vecs[0]  = '{32'd100,        32'd7,          OP_DIVU, 3'd1, 32'd14};
    vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          OP_REM,  3'd2, 32'hFFFF_FFFF};
    vecs[2]  = '{32'hFFFF_FFF9,  32'd2,          OP_DIV,  3'd3, 32'hFFFF_FFFD};
    vecs[3]  = '{32'h8000_0000,  32'hFFFF_FFFF,  OP_DIV,  3'd4, 32'h8000_0000};
    vecs[4]  = '{32'h8000_0000,  32'hFFFF_FFFF,  OP_REM,  3'd5, 32'd0};
    vecs[5]  = '{32'd5,          32'd0,          OP_DIV,  3'd6, 32'hFFFF_FFFF};
    vecs[6]  = '{32'd5,          32'd0,          OP_REMU, 3'd7, 32'd5};
    vecs[7]  = '{32'hFFFF_FFFB,  32'd0,          OP_REM,  3'd0, 32'hFFFF_FFFB};
    vecs[8]  = '{32'hFFFF_FFFB,  32'd0,          OP_DIV,  3'd1, 32'hFFFF_FFFF};
    vecs[9]  = '{32'hFFFF_FFFF,  32'd1,          OP_DIVU, 3'd2, 32'hFFFF_FFFF};
    vecs[10] = '{32'hFFFF_FFFF,  32'h10,         OP_REMU, 3'd3, 32'hF};
    vecs[11] = '{32'd7,          32'hFFFF_FFFE,  OP_DIV,  3'd4, 32'hFFFF_FFFD};
    vecs[12] = '{32'd7,          32'hFFFF_FFFE,  OP_REM,  3'd5, 32'd1};
    vecs[13] = '{32'h8000_0000,  32'd3,          OP_DIVU, 3'd6, 32'h2AAA_AAAA};
    vecs[14] = '{32'h8000_0000,  32'd3,          OP_REMU, 3'd7, 32'd2};
    vecs[15] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  OP_DIVU, 3'd0, 32'd1};

    rst           = 1'b1;
    fifo_valid    = 1'b1;
    fifo_data_out = pack(32'd9, 32'd3, OP_DIVU, 3'd7);
    wb_ack        = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_pop", fifo_pop, 0);
    check("rst_valid", wb_valid, 0);
    check("rst_rd", wb_rd, 0);
    check("rst_id", wb_id, 0);
    @(negedge clk);
    rst        = 1'b0;
    fifo_valid = 1'b0;

    for (int i = 0; i < 16; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      issue(nm, pack(vecs[i].rs1, vecs[i].rs2, vecs[i].op, vecs[i].id));
      wait_result(nm, vecs[i].exp_rd, vecs[i].id, exp_lat(vecs[i].rs2), 1'b0, '0);
      ack(nm);
    end

    // Two queued requests; the first result is held for 10 cycles without ack.
    issue("stallA", pack(32'd1000, 32'd10, OP_DIVU, 3'd1));
    wait_result("stallA", 32'd100, 3'd1, 34, 1'b1, pack(32'd1000, 32'd7, OP_REMU, 3'd2));
    repeat (10) begin
      @(negedge clk);
      #1;
      check("stall_valid", wb_valid, 1);
      check("stall_rd", wb_rd, 32'd100);
      check("stall_id", wb_id, 32'd1);
      check("stall_nopop", fifo_pop, 0);
    end
    wb_ack = 1'b1;
    #1 check("stall_ackpop", fifo_pop, 0);
    @(negedge clk);
    wb_ack = 1'b0;
    #1 check("stallB_pop", fifo_pop, 1);
    wait_result("stallB", 32'd6, 3'd2, 34, 1'b0, '0);
    ack("stallB");

    // Reset in the middle of DIVIDE with another request already waiting.
    issue("rstC", pack(32'd12345, 32'd5, OP_DIVU, 3'd3));
    @(negedge clk);
    fifo_valid = 1'b0;
    repeat (14) @(negedge clk);
    rst           = 1'b1;
    fifo_valid    = 1'b1;
    fifo_data_out = pack(32'hFFFF_FF9C, 32'd7, OP_DIV, 3'd5);
    #1;
    check("rstmid_pop", fifo_pop, 0);
    check("rstmid_valid", wb_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstD_pop", fifo_pop, 1);
    check("rstD_rd_cleared", wb_rd, 0);
    check("rstD_valid", wb_valid, 0);
    wait_result("rstD", 32'hFFFF_FFF2, 3'd5, 34, 1'b0, '0);
    ack("rstD");
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (wb_valid) seen++;
    end
    check("rst_no_stale", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
